imem_loader: RTL

//  Writer side of the instruction memory: accepts a program as a byte stream over a valid/ready handshake.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared instruction-memory sizes and loader state encodings
// Purpose: constants shared by the instruction memory and its loader.
// Ports:   none (package).
package imem_loader_pkg;

   localparam int IM_ADDR_W = 5;
   localparam int IM_DEPTH  = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_BYTES = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - assembles four stream bytes into a little-endian word
// Purpose: holds the byte lane index and the 32-bit lane register for the loader.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       restart lane indexing at byte 0 (start of a program)
//   strobe      byte_data is accepted this cycle
//   byte_data   stream byte to place in the current lane
//   word        assembled word (first byte in bits 7:0)
//   word_full   the byte being accepted completes the word
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        strobe,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] byte_idx;

   // Combinational so the loader can enter its write state on the same edge
   // that stores the fourth byte.
   assign word_full = strobe && (byte_idx == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx <= 2'd0;
         word     <= 32'd0;
      end else if (clear) begin
         byte_idx <= 2'd0;
      end else if (strobe) begin
         word[{byte_idx, 3'b000} +: 8] <= byte_data;
         byte_idx                      <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream writer for the instruction memory
// Purpose: receives a length byte then program bytes, writes words from address 0
//          upwards and stalls the core for the duration of the load.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   start            request a load (taken in IDLE, DONE or ERR)
//   in_valid/in_ready/in_data   byte stream handshake
//   mem_we/mem_addr/mem_wdata   instruction memory write port
//   cpu_hold         core stall while loading
//   done             one-cycle pulse after the last word is written
//   error            held while a bad length byte is pending recovery
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IM_ADDR_W,
   parameter int DEPTH  = IM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t          state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   len;
   logic            len_xfer;
   logic            byte_xfer;
   logic            word_full;
   logic            len_bad;

   assign len_xfer  = (state == S_LEN)   && in_valid;
   assign byte_xfer = (state == S_BYTES) && in_valid;
   assign len_bad   = (in_data == 8'd0) || (in_data > DEPTH_B);
   assign mem_addr  = addr;

   word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (len_xfer),
      .strobe    (byte_xfer),
      .byte_data (in_data),
      .word      (mem_wdata),
      .word_full (word_full)
   );

   // Outputs are loaded alongside each state transition so they always
   // reflect the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         addr     <= '0;
         len      <= '0;
         in_ready <= 1'b0;
         mem_we   <= 1'b0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LEN;
                  in_ready <= 1'b1;
                  cpu_hold <= 1'b1;
               end
            end
            S_LEN: begin
               if (in_valid) begin
                  len <= in_data[ADDR_W:0];
                  if (len_bad) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= S_BYTES;
                     addr  <= '0;
                  end
               end
            end
            S_BYTES: begin
               if (word_full) begin
                  state    <= S_WRITE;
                  in_ready <= 1'b0;
                  mem_we   <= 1'b1;
               end
            end
            S_WRITE: begin
               if ({1'b0, addr} == len - 1'b1) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= S_BYTES;
                  addr     <= addr + 1'b1;
                  in_ready <= 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  state    <= S_LEN;
                  in_ready <= 1'b1;
               end else begin
                  state    <= S_IDLE;
                  cpu_hold <= 1'b0;
               end
            end
            S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  in_ready <= 1'b1;
                  error    <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               cpu_hold <= 1'b0;
               error    <= 1'b0;
            end
         endcase
      end
   end

endmodule
